// File: rtl/cache_block_store_if.sv
// Controller/memory-side bus of the direct-mapped cache block store.
// The master side drives commands and memory beats; the slave side is the store.
interface cache_block_store_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              cache_read;
  logic              cache_write;
  logic              hit;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              refill_done;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       access_count;
  logic [15:0]       hit_count;

  modport master (
    output address, cache_read, cache_write, mem_valid, mem_rdata,
    input  hit, data_out, data_valid, busy, refill_done, mem_req, mem_addr,
           access_count, hit_count
  );

  modport slave (
    input  address, cache_read, cache_write, mem_valid, mem_rdata,
    output hit, data_out, data_valid, busy, refill_done, mem_req, mem_addr,
           access_count, hit_count
  );
endinterface

// File: rtl/cache_block_store.sv
// Direct-mapped cache data/tag store: serves reads, refills 4-word blocks from
// main memory on write commands, and keeps saturating access/hit counters.
module cache_block_store #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 2
) (
  input  logic               clk,
  input  logic               clear_n,
  cache_block_store_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_e;

  state_e                state_q, state_d;
  logic [OFFSET_W-1:0]   beat_q, beat_d;
  logic [TAG_W-1:0]      rtag_q, rtag_d;
  logic [INDEX_W-1:0]    ridx_q, ridx_d;
  logic [LINES-1:0]      valid_q;
  logic [DATA_W-1:0]     data_out_q;
  logic                  data_valid_q;
  logic [15:0]           acc_q;
  logic [15:0]           hitc_q;

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_W-1:0]     data_mem [LINES*WORDS];

  logic [OFFSET_W-1:0]   a_off;
  logic [INDEX_W-1:0]    a_idx;
  logic [TAG_W-1:0]      a_tag;
  logic                  busy;
  logic                  hit;
  logic                  rd_accept;
  logic                  fill_we;
  logic                  fill_last;
  logic                  inval;

  assign a_off = bus.address[OFFSET_W-1:0];
  assign a_idx = bus.address[OFFSET_W +: INDEX_W];
  assign a_tag = bus.address[ADDR_W-1 -: TAG_W];

  assign busy = (state_q != IDLE);
  assign hit  = valid_q[a_idx] && (tag_mem[a_idx] == a_tag) && !busy;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rtag_d    = rtag_q;
    ridx_d    = ridx_q;
    rd_accept = 1'b0;
    fill_we   = 1'b0;
    fill_last = 1'b0;
    inval     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cache_write) begin
          rtag_d  = a_tag;
          ridx_d  = a_idx;
          state_d = REQ;
        end else if (bus.cache_read) begin
          rd_accept = 1'b1;
        end
      end
      REQ: begin
        // Line is invalidated on entry to FILL so a partial block never hits
        beat_d  = '0;
        inval   = 1'b1;
        state_d = FILL;
      end
      FILL: begin
        if (bus.mem_valid) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == '1) begin
            fill_last = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      rtag_q       <= '0;
      ridx_q       <= '0;
      valid_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      acc_q        <= '0;
      hitc_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      rtag_q       <= rtag_d;
      ridx_q       <= ridx_d;
      data_valid_q <= rd_accept && hit;
      if (inval) begin
        valid_q[ridx_q] <= 1'b0;
      end else if (fill_last) begin
        valid_q[ridx_q] <= 1'b1;
      end
      if (rd_accept && hit) begin
        data_out_q <= data_mem[{a_idx, a_off}];
      end
      if (rd_accept && (acc_q != '1)) begin
        acc_q <= acc_q + 16'd1;
      end
      if (rd_accept && hit && (hitc_q != '1)) begin
        hitc_q <= hitc_q + 16'd1;
      end
    end
  end

  // Arrays carry no reset; the valid bits alone qualify their contents
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[{ridx_q, beat_q}] <= bus.mem_rdata;
    end
    if (fill_last) begin
      tag_mem[ridx_q] <= rtag_q;
    end
  end

  assign bus.hit          = hit;
  assign bus.busy         = busy;
  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.mem_req      = (state_q == REQ);
  assign bus.refill_done  = (state_q == DONE);
  assign bus.mem_addr     = {rtag_q, ridx_q, {OFFSET_W{1'b0}}};
  assign bus.access_count = acc_q;
  assign bus.hit_count    = hitc_q;
endmodule

// File: doc/cache_block_store.md
# cache_block_store

Direct-mapped cache data/tag store that executes the cache_read and cache_write commands issued by the memory controller. It produces the hit flag the controller decodes on, returns the addressed word on a read, and on a write refills one 4-word block from main memory over a multi-beat memory interface. It also keeps saturating access and hit counters for hit-rate reporting.

## Interface
- ADDR_W, 15, word address width
- DATA_W, 32, word width
- INDEX_W, 8, line index width (256 lines)
- OFFSET_W, 2, word-in-block offset width (4 words per block); tag width is ADDR_W-INDEX_W-OFFSET_W (5)
- clk  input  1  system clock, all state changes on rising edge
- clear_n  input  1  asynchronous, active-low reset
- address  input  ADDR_W  word address: [1:0] offset, [9:2] index, [14:10] tag
- cache_read  input  1  read command, level, sampled each edge
- cache_write  input  1  refill command, level, sampled each edge
- hit  output  1  combinational: line valid AND tag match AND not busy
- data_out  output  DATA_W  registered read data
- data_valid  output  1  one-cycle pulse, data_out updated
- busy  output  1  refill in progress
- refill_done  output  1  one-cycle pulse at end of refill
- mem_req  output  1  one-cycle block request to main memory
- mem_addr  output  ADDR_W  block-aligned address, offset bits 0, stable while busy
- mem_valid  input  1  memory beat valid
- mem_rdata  input  DATA_W  memory beat data, word 0 first
- access_count  output  16  accepted reads, saturating
- hit_count  output  16  accepted reads that hit, saturating

## Operation
- Storage: 256 x 4 x DATA_W data array (not reset), 256 x 5 tag array (not reset), 256 valid bits (cleared by reset).
- FSM states: IDLE, REQ, FILL, DONE.
- IDLE: busy=0. If cache_write=1: latch tag/index of address into the refill registers, go to REQ. Otherwise, if cache_read=1: the read is accepted, access_count increments, and if hit=1 then hit_count increments, data_out gets the addressed word, and data_valid pulses. On a read miss, data_out holds its value and data_valid stays 0.
- Simultaneous cache_read and cache_write in IDLE: the write wins. The read is dropped and is not counted.
- REQ: mem_req=1 for exactly one cycle, mem_addr = {tag, index, 2'b00}; go to FILL.
- FILL: a 2-bit beat counter starts at 0. Each mem_valid=1 writes mem_rdata into data[index][beat] and increments beat. On the beat-3 write, also set tag[index], set valid[index]=1, and go to DONE. mem_valid=0 cycles stall with no limit.
- DONE: refill_done=1 for one cycle; go to IDLE.
- Outside IDLE: cache_read and cache_write are ignored (not counted). mem_valid outside FILL is ignored.
- valid[index] is cleared on entry to FILL, so a partially filled line never hits.
- Counters saturate at 16'hFFFF and hold.
- Reset, including mid-refill: state=IDLE, all valid bits 0, beat=0, counters 0. Every output is 0 during and after reset (hit=0 because all lines are invalid). The partial line is discarded.

## Timing
- hit has zero latency from address and array state. It is forced to 0 while busy.
- Read: cache_read sampled at edge E → data_out/data_valid valid in the cycle after E. One read per cycle is sustainable.
- Refill with back-to-back beats:
  - cache_write sampled at E0 → REQ (busy=1, mem_req=1) after E0.
  - FILL after E1; beats sampled at E2..E5.
  - DONE after E5, with the line valid from E5.
  - IDLE after E6, busy=0.
  - Minimum 6 cycles of busy. Each mem_valid gap adds one cycle.
- mem_addr and latched index are held constant from after E0 until IDLE.

## Test plan
- Reset, then cache_read at 15'h0123 → hit=0, access_count=1, hit_count=0, data_valid=0. Also check all outputs are 0 during clear_n=0.
- cache_write at 15'h0124, memory returns 32'hA0..A3 on consecutive cycles → mem_req one cycle with mem_addr=15'h0124, busy for exactly 6 cycles, refill_done one pulse. Then a read of 15'h0126 → hit=1 and data_out=32'hA2 next cycle, hit_count=1.
- Same index, different tag: refill 15'h0124, then read 15'h4124 → hit=0. Refill 15'h4124 → 15'h0124 now misses and 15'h4124 hits.
- mem_valid with 3 idle cycles inserted between beats 1 and 2 → busy lasts 9 cycles, all 4 words land correctly, hit=0 throughout busy.
- clear_n asserted after beat 2 of a refill → state IDLE, busy=0. A read of that block misses. A new refill then completes normally.
- cache_read and cache_write together in IDLE → refill starts, access_count unchanged. Drive 65540 reads → access_count stops at 16'hFFFF.
